mem_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the Fetch stage (instruction reads) and the Memory stage (loads and stores).
- Grants one requester at a time and drives a req/ack handshake to the memory.
- Returns registered read data and ack pulses to the winning requester, and raises stall flags that the pipeline uses to freeze.
- Data accesses have priority; a burst limit stops instruction fetch from starving. A timeout watchdog recovers from a memory that never acks.

---
 rtl/mips_mem_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT_DM,
        GRANT_IF
    } arb_state_t;

    localparam int unsigned DefAddrW = 32;
    localparam int unsigned DefDataW = 32;
    localparam int unsigned TmoW     = 8;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access,
// with data priority, a fetch anti-starvation burst limit and a no-ack watchdog.
module mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = DefAddrW,
    parameter int unsigned DATA_W       = DefDataW,
    parameter int unsigned MAX_DM_BURST = 2,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam logic [3:0]      MaxBurst  = 4'(MAX_DM_BURST);
    localparam logic [3:0]      BurstOne  = 4'd1;
    localparam logic [TmoW-1:0] TmoLast   = TmoW'(TIMEOUT - 1);
    localparam logic [TmoW-1:0] TmoOne    = TmoW'(1);

    arb_state_t        state_q;
    logic [3:0]        burst_q;
    logic [TmoW-1:0]   tmo_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, dm_rdata_q;
    logic              if_ack_q, dm_ack_q, bus_err_q;
    logic              idle_hold;

    // The cycle after a completion or abort is never arbitrated, so a requester
    // that saw its ack can drop req before it could be granted again.
    assign idle_hold = if_ack_q | dm_ack_q | bus_err_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            burst_q     <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if_ack_q  <= 1'b0;
            dm_ack_q  <= 1'b0;
            bus_err_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!idle_hold) begin
                        if (dm_req && (!if_req || (burst_q < MaxBurst))) begin
                            state_q     <= GRANT_DM;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= dm_we;
                            mem_addr_q  <= dm_addr;
                            mem_wdata_q <= dm_wdata;
                            tmo_q       <= '0;
                            if (!if_req) begin
                                burst_q <= '0;
                            end else if (burst_q < MaxBurst) begin
                                burst_q <= burst_q + BurstOne;
                            end
                        end else if (if_req) begin
                            state_q    <= GRANT_IF;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= if_addr;
                            tmo_q      <= '0;
                            burst_q    <= '0;
                        end
                    end
                end
                GRANT_DM, GRANT_IF: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                        if (state_q == GRANT_IF) begin
                            if_rdata_q <= mem_rdata;
                            if_ack_q   <= 1'b1;
                        end else begin
                            if (!mem_we_q) begin
                                dm_rdata_q <= mem_rdata;
                            end
                            dm_ack_q <= 1'b1;
                        end
                    end else if (tmo_q == TmoLast) begin
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + TmoOne;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ack    = dm_ack_q;
    assign dm_stall  = dm_req & ~dm_ack_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a programmable-latency memory.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ack, if_stall, dm_ack, dm_stall;
    logic        mem_req, mem_we, mem_ack, bus_err;

    int          checks = 0;
    int          failures = 0;
    int          wait_n = 0;
    int          cnt = 0;
    bit          no_ack = 1'b0;
    logic [31:0] log_q[$];

    always #5 clock = ~clock;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DM_BURST(2), .TIMEOUT(255)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    // Memory model: acks after wait_n cycles of mem_req (0 = same cycle).
    always @(posedge clock or negedge reset) begin
        if (!reset || !mem_req) cnt <= 0;
        else                    cnt <= cnt + 1;
    end
    always_comb mem_ack = mem_req && !no_ack && (cnt == wait_n);
    always @(posedge clock) if (reset && mem_req && mem_ack) log_q.push_back(mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, hi, errs, acks, stall_off;
        logic [31:0] exp_order [6];
        exp_order = '{32'h200, 32'h200, 32'h300, 32'h200, 32'h200, 32'h300};

        reset = 1'b0; if_req = 0; dm_req = 0; dm_we = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        repeat (2) @(negedge clock);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_acks", {30'd0, if_ack, dm_ack}, 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        reset = 1'b1;

        // Lone fetch, one wait state.
        @(negedge clock);
        wait_n = 1; mem_rdata = 32'h2008_0005; if_req = 1; if_addr = 32'h40;
        #1 chk("fetch_stall", 32'(if_stall), 32'd1);
        @(negedge clock);
        chk("fetch_mem_req", 32'(mem_req), 32'd1);
        chk("fetch_mem_addr", mem_addr, 32'h40);
        chk("fetch_mem_we", 32'(mem_we), 32'd0);
        cyc = 1;
        while (!if_ack && cyc < 20) begin @(negedge clock); cyc++; end
        chk("fetch_latency", 32'(cyc), 32'd3);
        chk("fetch_rdata", if_rdata, 32'h2008_0005);
        chk("fetch_stall_off", 32'(if_stall), 32'd0);
        if_req = 0;
        @(negedge clock);
        chk("fetch_ack_pulse", 32'(if_ack), 32'd0);

        // Store has priority over a simultaneous fetch.
        dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
        if_req = 1; if_addr = 32'h44; wait_n = 0; mem_rdata = 32'h1234_5678;
        @(negedge clock);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mem_addr", mem_addr, 32'h100);
        chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clock);
        chk("st_dm_ack", 32'(dm_ack), 32'd1);
        chk("st_if_ack", 32'(if_ack), 32'd0);
        chk("st_dm_stall", 32'(dm_stall), 32'd0);
        chk("st_rdata_held", dm_rdata, 32'd0);
        dm_req = 0; dm_we = 0;
        @(negedge clock);
        chk("st_idle_gap", 32'(mem_req), 32'd0);
        @(negedge clock);
        chk("st_then_if_addr", mem_addr, 32'h44);
        chk("st_then_if_we", 32'(mem_we), 32'd0);
        @(negedge clock);
        chk("st_then_if_ack", 32'(if_ack), 32'd1);
        chk("st_then_if_rdata", if_rdata, 32'h1234_5678);
        chk("st_rdata_still", dm_rdata, 32'd0);
        if_req = 0;
        @(negedge clock);

        // Anti-starvation with both requesters held.
        log_q.delete();
        dm_req = 1; dm_we = 0; dm_addr = 32'h200; if_req = 1; if_addr = 32'h300;
        stall_off = 0; acks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (!if_stall) stall_off++;
            if (dm_ack) acks++;
        end
        dm_req = 0; if_req = 0;
        repeat (2) @(negedge clock);
        chk("burst_grants", 32'(log_q.size()), 32'd7);
        for (int i = 0; i < 6; i++) begin
            if (i < log_q.size()) chk("burst_order", log_q[i], exp_order[i]);
            else                  chk("burst_order", 32'hFFFF_FFFF, exp_order[i]);
        end
        chk("burst_if_stall_off", 32'(stall_off), 32'd2);
        chk("burst_dm_acks", 32'(acks), 32'd5);

        // Timeout on a load that never gets acked.
        no_ack = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h400;
        hi = 0; errs = 0; acks = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (mem_req) hi++;
            if (dm_ack) acks++;
            if (bus_err) begin errs++; dm_req = 0; end
        end
        chk("tmo_req_cycles", 32'(hi), 32'd255);
        chk("tmo_bus_err", 32'(errs), 32'd1);
        chk("tmo_no_ack", 32'(acks), 32'd0);
        no_ack = 0; wait_n = 2; mem_rdata = 32'hCAFE_F00D;
        dm_req = 1; dm_addr = 32'h404;
        cyc = 0;
        while (!dm_ack && cyc < 20) begin @(negedge clock); cyc++; end
        chk("tmo_next_latency", 32'(cyc), 32'd4);
        chk("tmo_next_rdata", dm_rdata, 32'hCAFE_F00D);
        dm_req = 0;
        @(negedge clock);

        // Asynchronous reset in the middle of an access.
        no_ack = 1; if_req = 1; if_addr = 32'h500;
        repeat (2) @(negedge clock);
        chk("rstmid_req_before", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rstmid_mem_req", 32'(mem_req), 32'd0);
        chk("rstmid_outs", {29'd0, if_ack, dm_ack, bus_err}, 32'd0);
        if_req = 0;
        @(negedge clock);
        reset = 1'b1; no_ack = 0; wait_n = 0; mem_rdata = 32'h0BAD_CAFE;
        @(negedge clock);
        if_req = 1; if_addr = 32'h600;
        @(negedge clock);
        chk("rstmid_new_addr", mem_addr, 32'h600);
        @(negedge clock);
        chk("rstmid_new_ack", 32'(if_ack), 32'd1);
        chk("rstmid_new_rdata", if_rdata, 32'h0BAD_CAFE);
        if_req = 0;
        @(negedge clock);

        // Fetch request withdrawn right after grant still completes once.
        wait_n = 3; mem_rdata = 32'h7777_0001; if_req = 1; if_addr = 32'h700;
        @(negedge clock);
        chk("drop_granted", 32'(mem_req), 32'd1);
        if_req = 0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (if_ack) acks++;
        end
        chk("drop_ack_once", 32'(acks), 32'd1);
        chk("drop_rdata", if_rdata, 32'h7777_0001);
        chk("drop_idle", 32'(mem_req), 32'd0);
        wait_n = 0; mem_rdata = 32'h5555_AAAA; dm_req = 1; dm_addr = 32'h800;
        cyc = 0;
        while (!dm_ack && cyc < 20) begin @(negedge clock); cyc++; end
        chk("drop_next_latency", 32'(cyc), 32'd2);
        chk("drop_next_rdata", dm_rdata, 32'h5555_AAAA);
        dm_req = 0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
